// File: rtl/shift_down_pkg.sv
// Shared types and bus-layout helpers for the shift-down chain stage.
// The chain bus is packed as {vld, data, smc_id}, with vld at the MSB.
package shift_down_pkg;

    localparam int DEF_ID_W   = 5;
    localparam int DEF_DATA_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic int bus_vld_bit(input int data_w, input int id_w);
        return data_w + id_w;
    endfunction

    function automatic int bus_data_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int bus_data_msb(input int data_w, input int id_w);
        return data_w + id_w - 1;
    endfunction

endpackage

// File: rtl/shift_down_fifo.sv
// Output FIFO with two ordered write ports: port A lands ahead of port B in the same cycle.
// The head is visible combinationally. Callers must never push more than the free space.
module shift_down_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_a,
    input  logic [W-1:0]               din_a,
    input  logic                       push_b,
    input  logic [W-1:0]               din_b,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr;

    always_comb begin
        mem_d  = mem_q;
        wr_ptr = wr_ptr_q;
        if (push_a) begin
            mem_d[wr_ptr] = din_a;
            wr_ptr        = wr_ptr + 1'b1;
        end
        if (push_b) begin
            mem_d[wr_ptr] = din_b;
            wr_ptr        = wr_ptr + 1'b1;
        end
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/shift_down_burst.sv
// Shift-down chain stage: passes downstream-addressed beats, drops upstream ones,
// and on an address match streams UR_WORD_CNT local DVR words into the chain.
module shift_down_burst
    import shift_down_pkg::*;
#(
    parameter int SMC_ID      = 0,
    parameter int ID_W        = DEF_ID_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int UR_WORD_CNT = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W+ID_W:0]      crd_shiftdn_in,
    output logic                      crd_shiftdn_in_rdy,
    output logic                      dvr_rd_en,
    output logic [((UR_WORD_CNT > 1) ? $clog2(UR_WORD_CNT) : 1)-1:0] dvr_rd_idx,
    input  logic [DATA_W-1:0]         dvr_rd_data,
    output logic [DATA_W+ID_W:0]      crd_shiftdn_out,
    input  logic                      crd_shiftdn_out_rdy,
    output logic                      busy
);

    localparam int VLD_B = bus_vld_bit(DATA_W, ID_W);
    localparam int ID_HI = bus_data_lsb(ID_W) - 1;
    localparam int PAY_W = bus_data_msb(DATA_W, ID_W) + 1;
    localparam int IDX_W = (UR_WORD_CNT > 1) ? $clog2(UR_WORD_CNT) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ID_W-1:0]  MY_ID    = ID_W'(SMC_ID);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UR_WORD_CNT - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             inflight_q, inflight_d;

    logic             in_vld;
    logic [ID_W-1:0]  in_id;
    logic [CW-1:0]    fifo_count;
    logic [PAY_W-1:0] fifo_head;
    logic [PAY_W-1:0] dvr_word;
    logic             space;
    logic             rd_en;
    logic             push_pass;
    logic             in_rdy;
    logic             out_vld;
    logic             pop;

    assign in_vld   = crd_shiftdn_in[VLD_B];
    assign in_id    = crd_shiftdn_in[ID_HI:0];
    assign dvr_word = {dvr_rd_data, MY_ID};

    // The returning DVR word already owns a slot, so it counts against credit.
    assign space = (fifo_count + CW'(inflight_q)) < DEPTH_C;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_en     = 1'b0;
        push_pass = 1'b0;
        in_rdy    = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = space;
                if (in_vld && space) begin
                    if (in_id > MY_ID) begin
                        push_pass = 1'b1;
                    end else if (in_id == MY_ID) begin
                        state_d = BURST;
                        idx_d   = '0;
                    end
                end
            end
            BURST: begin
                if (space) begin
                    rd_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
        end
    end

    // A pass-through beat can arrive in the cycle the last burst word returns;
    // the burst word takes port A so it stays ahead of the later beat.
    shift_down_fifo #(
        .W     (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (inflight_q),
        .din_a  (dvr_word),
        .push_b (push_pass),
        .din_b  (crd_shiftdn_in[PAY_W-1:0]),
        .pop    (pop),
        .head   (fifo_head),
        .count  (fifo_count)
    );

    assign out_vld            = (fifo_count != '0);
    assign pop                = out_vld && crd_shiftdn_out_rdy;
    assign crd_shiftdn_out    = out_vld ? {1'b1, fifo_head} : '0;
    assign crd_shiftdn_in_rdy = in_rdy;
    assign dvr_rd_en          = rd_en;
    assign dvr_rd_idx         = idx_q;
    assign busy               = (state_q != IDLE) || out_vld;

endmodule

// File: tb/tb_shift_down_burst.sv
// Bench for shift_down_burst: directed cycle-level checks plus an ordered-queue
// model of what the chain output must carry, checked every cycle.
module tb_shift_down_burst;

    localparam int SMC_ID = 3;
    localparam int ID_W   = 5;
    localparam int DATA_W = 128;
    localparam int URC    = 4;
    localparam int DEPTH  = 4;
    localparam int BW     = 1 + DATA_W + ID_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BW-1:0]     in_bus = '0;
    logic              in_rdy;
    logic              rd_en;
    logic [1:0]        rd_idx;
    logic [DATA_W-1:0] rd_data = '0;
    logic [BW-1:0]     out_bus;
    logic              out_rdy = 1'b1;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_down_burst #(
        .SMC_ID      (SMC_ID),
        .ID_W        (ID_W),
        .DATA_W      (DATA_W),
        .UR_WORD_CNT (URC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .crd_shiftdn_in      (in_bus),
        .crd_shiftdn_in_rdy  (in_rdy),
        .dvr_rd_en           (rd_en),
        .dvr_rd_idx          (rd_idx),
        .dvr_rd_data         (rd_data),
        .crd_shiftdn_out     (out_bus),
        .crd_shiftdn_out_rdy (out_rdy),
        .busy                (busy)
    );

    // DVR: word idx is 0x1000+idx, one cycle after the strobe.
    always @(posedge clk) if (rd_en) rd_data <= DATA_W'(32'h1000 + 32'(rd_idx));

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic v, input logic [DATA_W-1:0] d,
                                         input logic [ID_W-1:0] id);
        return {v, d, id};
    endfunction

    function automatic logic [BW-1:0] wrd(input int k);
        return mk(1'b1, DATA_W'(32'h1000 + k), ID_W'(SMC_ID));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: every accepted beat decides, in acceptance order, what the output must carry.
    logic [BW-2:0] expq[$];
    int            rd_exp = 0;
    logic [BW-1:0] mtmp;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            rd_exp = 0;
        end else begin
            if (out_bus[BW-1]) begin
                if (expq.size() == 0) chk("out_unexpected", out_bus, '0);
                else begin
                    chk("out_vs_model", out_bus, {1'b1, expq[0]});
                    if (out_rdy) void'(expq.pop_front());
                end
            end else begin
                chk("out_idle_zero", out_bus, '0);
            end
            if (rd_en) begin
                chk("rd_within_burst", BW'(rd_exp < URC), BW'(1));
                chk("rd_idx_order", BW'(rd_idx), BW'(rd_exp));
                rd_exp++;
            end
            if (in_bus[BW-1] && in_rdy) begin
                if (in_bus[ID_W-1:0] > ID_W'(SMC_ID)) begin
                    expq.push_back(in_bus[BW-2:0]);
                end else if (in_bus[ID_W-1:0] == ID_W'(SMC_ID)) begin
                    for (int k = 0; k < URC; k++) begin
                        mtmp = wrd(k);
                        expq.push_back(mtmp[BW-2:0]);
                    end
                    rd_exp = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [BW-1:0] pa, p7, bp_exp;
    logic [BW-1:0] seen[$];
    logic          acc;

    initial begin
        step();
        step();
        chk("rst_out", out_bus, '0);
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_rd_en", BW'(rd_en), BW'(0));
        chk("rst_rd_idx", BW'(rd_idx), BW'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_rdy", BW'(in_rdy), BW'(1));
        step();

        // Pass-through
        pa = mk(1'b1, {16{8'hA5}}, 5'd4);
        in_bus = pa;
        chk("pass_in_rdy", BW'(in_rdy), BW'(1));
        step();
        in_bus = '0;
        chk("pass_out", out_bus, pa);
        step();
        chk("pass_gone", out_bus, '0);

        // Burst: command accepted at edge N
        in_bus = mk(1'b1, '1, 5'd3);
        step();
        in_bus = '0;
        for (int k = 0; k < URC; k++) begin
            chk("burst_rd_en", BW'(rd_en), BW'(1));
            chk("burst_rd_idx", BW'(rd_idx), BW'(k));
            chk("burst_in_rdy_low", BW'(in_rdy), BW'(0));
            chk("burst_out", out_bus, (k >= 2) ? wrd(k - 2) : '0);
            step();
        end
        chk("burst_rd_done", BW'(rd_en), BW'(0));
        chk("burst_in_rdy_back", BW'(in_rdy), BW'(1));
        chk("burst_out_w2", out_bus, wrd(2));
        step();
        chk("burst_out_w3", out_bus, wrd(3));
        step();
        chk("burst_out_end", out_bus, '0);
        chk("burst_busy_end", BW'(busy), BW'(0));

        // Drop and invalid beats
        in_bus = mk(1'b1, {8{16'h2222}}, 5'd2);
        step();
        in_bus = mk(1'b0, {16{8'hBB}}, 5'd3);
        for (int k = 0; k < 4; k++) begin
            chk("drop_rd_en", BW'(rd_en), BW'(0));
            chk("drop_out", out_bus, '0);
            chk("drop_busy", BW'(busy), BW'(0));
            step();
            in_bus = '0;
        end

        // Back-pressure
        out_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_bus = mk(1'b1, DATA_W'(i), 5'd5);
            chk("bp_in_rdy", BW'(in_rdy), BW'(1));
            step();
        end
        in_bus = '0;
        bp_exp = mk(1'b1, DATA_W'(1), 5'd5);
        chk("bp_full_rdy", BW'(in_rdy), BW'(0));
        in_bus = mk(1'b1, '0, 5'd3);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_rdy", BW'(in_rdy), BW'(0));
            chk("bp_hold_rd", BW'(rd_en), BW'(0));
            chk("bp_hold_out", out_bus, bp_exp);
            step();
        end
        out_rdy = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (out_bus[BW-1]) seen.push_back(out_bus);
            if (in_bus[BW-1] && in_rdy) acc = 1'b1;
            step();
            if (acc) in_bus = '0;
        end
        chk("bp_cmd_taken", BW'(acc), BW'(1));
        chk("bp_beat_count", BW'(seen.size()), BW'(8));
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            bp_exp = (i < 4) ? mk(1'b1, DATA_W'(i + 1), 5'd5) : wrd(i - 4);
            chk("bp_order", seen[i], bp_exp);
        end

        // Reset mid-burst
        in_bus = mk(1'b1, '0, 5'd3);
        step();
        in_bus = '0;
        step();
        chk("mr_idx1_rd", BW'(rd_en), BW'(1));
        chk("mr_idx1", BW'(rd_idx), BW'(1));
        step();
        rst = 1'b1;
        #1;
        chk("mr_out", out_bus, '0);
        chk("mr_rd_en", BW'(rd_en), BW'(0));
        chk("mr_rd_idx", BW'(rd_idx), BW'(0));
        chk("mr_busy", BW'(busy), BW'(0));
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("mr_no_reads", BW'(rd_en), BW'(0));
            chk("mr_out_idle", out_bus, '0);
            step();
        end
        p7 = mk(1'b1, {4{32'hCAFE0007}}, 5'd7);
        in_bus = p7;
        chk("mr_in_rdy", BW'(in_rdy), BW'(1));
        step();
        in_bus = '0;
        chk("mr_pass", out_bus, p7);
        step();
        chk("mr_pass_gone", out_bus, '0);
        step();
        chk("model_drained", BW'(expq.size()), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
